// File: rtl/seg_scan_mux.sv
// Scans four hex digits onto a common-anode 7-segment display, with a per-slot ghosting guard.
// Value/dp/blank reach the display through a pending register and a frame-synchronous shadow register.
module seg_scan_mux #(
    parameter int TICK_DIV     = 100000,
    parameter int GHOST_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blank_i,
    output logic [3:0]  digit_o,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_o,
    output logic        pending_o
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST_CYCLES);

    generate
        if (TICK_DIV < 2 || GHOST_CYCLES >= TICK_DIV) begin : g_bad_params
            $error("seg_scan_mux: need TICK_DIV >= 2 and GHOST_CYCLES < TICK_DIV");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_shadow_val;
    logic [3:0]       r_shadow_dp;
    logic [3:0]       r_shadow_blank;
    logic [15:0]      r_pend_val;
    logic [3:0]       r_pend_dp;
    logic [3:0]       r_pend_blank;
    logic             r_pend_v;

    logic             w_tick;
    logic             w_off;

    assign w_tick  = (r_cnt == CNT_LAST);
    assign frame_o = w_tick && (r_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_idx          <= 2'd0;
            r_shadow_val   <= 16'h0000;
            r_shadow_dp    <= 4'b0000;
            r_shadow_blank <= 4'b1111;
            r_pend_val     <= 16'h0000;
            r_pend_dp      <= 4'b0000;
            r_pend_blank   <= 4'b0000;
            r_pend_v       <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // A load coinciding with the boundary bypasses pending so it is not lost for a frame.
            if (frame_o) begin
                if (load_i) begin
                    r_shadow_val   <= value_i;
                    r_shadow_dp    <= dp_i;
                    r_shadow_blank <= blank_i;
                end else if (r_pend_v) begin
                    r_shadow_val   <= r_pend_val;
                    r_shadow_dp    <= r_pend_dp;
                    r_shadow_blank <= r_pend_blank;
                end
                r_pend_v <= 1'b0;
            end else if (load_i) begin
                r_pend_val   <= value_i;
                r_pend_dp    <= dp_i;
                r_pend_blank <= blank_i;
                r_pend_v     <= 1'b1;
            end
        end
    end

    assign w_off     = (r_cnt < GHOST_END) || r_shadow_blank[r_idx];
    assign an        = w_off ? 4'b1111 : ~(4'b0001 << r_idx);
    assign dp        = ~(r_shadow_dp[r_idx] && !w_off);
    assign digit_o   = r_shadow_val[{r_idx, 2'b00} +: 4];
    assign pending_o = r_pend_v;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux at TICK_DIV=8, GHOST_CYCLES=2: lit-digit scoreboard plus directed timing checks.
module tb_seg_scan_mux;

    localparam int TD = 8;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic [3:0]  digit_o;
    logic [3:0]  an;
    logic        dp;
    logic        frame_o;
    logic        pending_o;

    seg_scan_mux #(.TICK_DIV(TD), .GHOST_CYCLES(GC)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_i),
        .value_i   (value_i),
        .dp_i      (dp_i),
        .blank_i   (blank_i),
        .digit_o   (digit_o),
        .an        (an),
        .dp        (dp),
        .frame_o   (frame_o),
        .pending_o (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dig;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Every cycle with a lit anode must match the next expected lit-digit record.
    always @(negedge clk) begin
        if (an != 4'b1111) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_lit: an=%b digit=%h dp=%b, required all anodes off", an, digit_o, dp);
            end else begin
                mon_e = sb_q.pop_front();
                if ({an, digit_o, dp} !== mon_e) begin
                    failures++;
                    $display("FAIL sb_lit_digit: an=%b digit=%h dp=%b, required an=%b digit=%h dp=%b",
                             an, digit_o, dp, mon_e.an, mon_e.dig, mon_e.dp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        load_i  = 1'b1;
        value_i = v;
        dp_i    = d;
        blank_i = b;
        @(negedge clk);
        load_i  = 1'b0;
    endtask

    // Queue the 6 lit cycles of every non-blanked digit of one frame.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (!b[i]) begin
                for (int j = 0; j < TD - GC; j++) begin
                    e.an  = 4'(~(4'b0001 << i));
                    e.dig = v[4*i +: 4];
                    e.dp  = ~d[i];
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    // Returns on the negedge where frame_o is high.
    task automatic wait_frame();
        bit found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (frame_o) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_timeout: got no frame_o in 100 cycles, required one");
        end
    endtask

    // Cycle-exact check of one full frame, starting the cycle after a frame_o.
    task automatic check_frame_cycles(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        logic [3:0] ea;
        logic       ed;
        int         slot;
        int         cn;
        for (int c = 0; c < 4 * TD; c++) begin
            @(negedge clk);
            slot = c / TD;
            cn   = c % TD;
            ea   = (cn < GC || b[slot]) ? 4'b1111 : 4'(~(4'b0001 << slot));
            ed   = ~(d[slot] && ea != 4'b1111);
            chk("cyc_an", 16'(an), 16'(ea));
            chk("cyc_dp", 16'(dp), 16'(ed));
            chk("cyc_digit", 16'(digit_o), 16'(v[4*slot +: 4]));
            chk("cyc_frame", 16'(frame_o), 16'(c == 4 * TD - 1));
        end
    endtask

    int frames;

    initial begin
        rst     = 1'b1;
        load_i  = 1'b0;
        value_i = 16'h0000;
        dp_i    = 4'b0000;
        blank_i = 4'b0000;

        // Reset state
        step(3);
        chk("rst_an", 16'(an), 16'h000F);
        chk("rst_dp", 16'(dp), 16'h0001);
        chk("rst_pending", 16'(pending_o), 16'h0000);
        chk("rst_digit", 16'(digit_o), 16'h0000);
        chk("rst_frame", 16'(frame_o), 16'h0000);
        rst    = 1'b0;
        frames = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_o) frames++;
        end
        chk("idle_frames", 16'(frames), 16'h0001);
        chk("idle_an", 16'(an), 16'h000F);

        // Scan order
        load(16'h1234, 4'b0000, 4'b0000);
        chk("load1_pending", 16'(pending_o), 16'h0001);
        wait_frame();
        push_frame(16'h1234, 4'b0000, 4'b0000);
        check_frame_cycles(16'h1234, 4'b0000, 4'b0000);
        chk("scan_pending", 16'(pending_o), 16'h0000);

        // Tear-free update: load during idx=1 must not disturb the current frame
        push_frame(16'h1234, 4'b0000, 4'b0000);
        step(10);
        load(16'hABCD, 4'b0000, 4'b0000);
        chk("tear_pending", 16'(pending_o), 16'h0001);
        wait_frame();
        chk("tear_pending_at_frame", 16'(pending_o), 16'h0001);
        push_frame(16'hABCD, 4'b0000, 4'b0000);
        step(1);
        chk("tear_pending_clr", 16'(pending_o), 16'h0000);
        chk("tear_digit0", 16'(digit_o), 16'h000D);

        // Load on the boundary cycle wins over an older pending value
        load(16'h5555, 4'b0000, 4'b0000);
        chk("sim_pending", 16'(pending_o), 16'h0001);
        wait_frame();
        load_i  = 1'b1;
        value_i = 16'h9999;
        push_frame(16'h9999, 4'b0000, 4'b0000);
        step(1);
        load_i  = 1'b0;
        chk("sim_pending_clr", 16'(pending_o), 16'h0000);

        // Two loads before a boundary: last one is displayed
        load(16'h0F0F, 4'b0000, 4'b0000);
        load(16'h3C5A, 4'b0000, 4'b0000);
        chk("two_pending", 16'(pending_o), 16'h0001);
        wait_frame();
        push_frame(16'h3C5A, 4'b0000, 4'b0000);
        step(1);
        chk("two_pending_clr", 16'(pending_o), 16'h0000);

        // Blank digit 2, decimal point on digit 0
        load(16'h4321, 4'b0001, 4'b0100);
        wait_frame();
        push_frame(16'h4321, 4'b0001, 4'b0100);
        check_frame_cycles(16'h4321, 4'b0001, 4'b0100);

        // Reset at idx=2 with a pending load discards everything
        push_frame(16'h4321, 4'b0001, 4'b0100);
        step(1);
        load(16'h7777, 4'b0000, 4'b0000);
        chk("rst2_pending_set", 16'(pending_o), 16'h0001);
        step(17);
        rst = 1'b1;
        sb_q.delete();
        step(1);
        chk("rst2_pending", 16'(pending_o), 16'h0000);
        chk("rst2_an", 16'(an), 16'h000F);
        chk("rst2_digit", 16'(digit_o), 16'h0000);
        step(2);
        rst    = 1'b0;
        frames = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_o) frames++;
        end
        chk("rst2_frames", 16'(frames), 16'h0001);
        chk("rst2_idle_an", 16'(an), 16'h000F);
        chk("rst2_idle_pending", 16'(pending_o), 16'h0000);

        chk("sb_drained", 16'(sb_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
